// File: rtl/booth_mac_sequencer_pkg.sv
// Shared definitions for the radix-4 Booth MAC sequencer: FSM encoding,
// Booth digit triples and the triple -> partial-product control mapping.
package booth_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] TRIPLE_Z0  = 3'b000;
    localparam logic [2:0] TRIPLE_P1A = 3'b001;
    localparam logic [2:0] TRIPLE_P1B = 3'b010;
    localparam logic [2:0] TRIPLE_P2  = 3'b011;
    localparam logic [2:0] TRIPLE_M2  = 3'b100;
    localparam logic [2:0] TRIPLE_M1A = 3'b101;
    localparam logic [2:0] TRIPLE_M1B = 3'b110;
    localparam logic [2:0] TRIPLE_Z1  = 3'b111;

    typedef struct packed {
        logic shift;
        logic neg;
        logic zero;
    } booth_ctrl_t;

    function automatic booth_ctrl_t booth_decode(input logic [2:0] triple);
        booth_ctrl_t ctrl;
        ctrl = '{shift: 1'b0, neg: 1'b0, zero: 1'b1};
        case (triple)
            TRIPLE_Z0, TRIPLE_Z1:   ctrl = '{shift: 1'b0, neg: 1'b0, zero: 1'b1};
            TRIPLE_P1A, TRIPLE_P1B: ctrl = '{shift: 1'b0, neg: 1'b0, zero: 1'b0};
            TRIPLE_P2:              ctrl = '{shift: 1'b1, neg: 1'b0, zero: 1'b0};
            TRIPLE_M2:              ctrl = '{shift: 1'b1, neg: 1'b1, zero: 1'b0};
            TRIPLE_M1A, TRIPLE_M1B: ctrl = '{shift: 1'b0, neg: 1'b1, zero: 1'b0};
            default:                ctrl = '{shift: 1'b0, neg: 1'b0, zero: 1'b1};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/booth_mac_sequencer_digit_encoder.sv
// Combinational Booth radix-4 digit encoder: 3-bit multiplier window to
// Shift/Negation/Zero controls for the partial-product unit.
module booth_digit_encoder
    import booth_mac_sequencer_pkg::*;
(
    input  logic [2:0] triple,
    output logic       shift,
    output logic       neg,
    output logic       zero
);

    booth_ctrl_t ctrl_s;

    // Decode the current digit window.
    always_comb begin
        ctrl_s = booth_decode(triple);
        shift  = ctrl_s.shift;
        neg    = ctrl_s.neg;
        zero   = ctrl_s.zero;
    end

endmodule

// File: rtl/booth_mac_sequencer.sv
// Multi-cycle radix-4 Booth MAC controller: issues one Booth digit per cycle
// to an external partial-product unit and accumulates the weighted results.
module booth_mac_sequencer
    import booth_mac_sequencer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     InMultiplicant,
    input  logic [WIDTH-1:0]     InMultiplier,
    input  logic                 InClear,
    output logic [WIDTH-1:0]     PpMultiplicant,
    output logic                 PpShift,
    output logic                 PpNegation,
    output logic                 PpZero,
    input  logic [WIDTH:0]       PpResult,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [ACC_WIDTH-1:0] OutAcc,
    output logic                 OutRangeErr
);

    localparam int ND    = WIDTH / 2;
    localparam int CNT_W = $clog2(ND) + 1;

    state_t                 state_r;
    state_t                 state_s;
    logic [WIDTH-1:0]       mcand_r;
    logic [WIDTH:0]         mplier_r;   // multiplier with implicit b[-1]=0 appended
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   err_r;

    logic [CNT_W:0]         shamt_s;
    logic [2:0]             triple_s;
    logic                   enc_shift_s;
    logic                   enc_neg_s;
    logic                   enc_zero_s;
    logic                   last_s;
    logic                   range_s;
    logic [ACC_WIDTH-1:0]   pp_ext_s;
    logic [ACC_WIDTH-1:0]   pp_weighted_s;

    assign shamt_s  = {cnt_r, 1'b0};
    assign triple_s = 3'(mplier_r >> shamt_s);

    booth_digit_encoder u_enc (
        .triple (triple_s),
        .shift  (enc_shift_s),
        .neg    (enc_neg_s),
        .zero   (enc_zero_s)
    );

    // Partial-product controls, weighting and range check of the current digit.
    always_comb begin
        PpShift       = 1'b0;
        PpNegation    = 1'b0;
        PpZero        = 1'b1;
        if (state_r == ST_RUN) begin
            PpShift    = enc_shift_s;
            PpNegation = enc_neg_s;
            PpZero     = enc_zero_s;
        end else begin
            PpShift    = 1'b0;
            PpNegation = 1'b0;
            PpZero     = 1'b1;
        end
        last_s        = (cnt_r == CNT_W'(ND - 1));
        // -2 times the most negative multiplicand overflows WIDTH+1 bits.
        range_s       = enc_shift_s & enc_neg_s &
                        (mcand_r == {1'b1, {(WIDTH-1){1'b0}}});
        pp_ext_s      = {{(ACC_WIDTH-WIDTH-1){PpResult[WIDTH]}}, PpResult};
        pp_weighted_s = pp_ext_s << shamt_s;
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (InValid) state_s = ST_RUN;
                else         state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (OutReady) state_s = ST_IDLE;
                else          state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand latch, digit counter, accumulator and range flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {(WIDTH+1){1'b0}};
            acc_r    <= {ACC_WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (InValid) begin
                        mcand_r  <= InMultiplicant;
                        mplier_r <= {InMultiplier, 1'b0};
                        cnt_r    <= {CNT_W{1'b0}};
                        err_r    <= 1'b0;
                        if (InClear) acc_r <= {ACC_WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_r + pp_weighted_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (range_s) err_r <= 1'b1;
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign InReady        = (state_r == ST_IDLE);
    assign OutValid       = (state_r == ST_DONE);
    assign OutAcc         = acc_r;
    assign OutRangeErr    = err_r;
    assign PpMultiplicant = mcand_r;

endmodule

// File: doc/booth_mac_sequencer.md
Name: booth_mac_sequencer

Overview:
Multi-cycle radix-4 Booth MAC controller for the NPU MAC unit. It accepts signed Multiplicant/Multiplier pairs over a valid/ready handshake and issues one Booth digit per cycle to the external Multiplier_4X4 partial-product unit through its Shift/Negation/Zero controls. It accumulates the returned partial products, weighted by digit position, into a signed accumulator. It sits between the NPU operand feeder and the 5-bit partial-product datapath.

Parameters:
WIDTH, 4, operand width in bits (even, >=4); digit count ND = WIDTH/2; partial-product width WIDTH+1
ACC_WIDTH, 12, accumulator width (signed, two's complement)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
InValid  input  1  operand pair valid
InReady  output  1  block can accept an operand pair
InMultiplicant  input  WIDTH  signed multiplicand
InMultiplier  input  WIDTH  signed multiplier (Booth-recoded)
InClear  input  1  1: accumulator starts from 0 for this op; 0: accumulate onto the held value
PpMultiplicant  output  WIDTH  latched multiplicand to the partial-product unit
PpShift  output  1  digit magnitude 2 (multiplicand<<1)
PpNegation  output  1  negative digit
PpZero  output  1  zero digit
PpResult  input  WIDTH+1  signed partial product returned combinationally, same cycle
OutValid  output  1  accumulator result valid
OutReady  input  1  consumer accepts result
OutAcc  output  ACC_WIDTH  signed accumulator value
OutRangeErr  output  1  a digit this op produced an unrepresentable partial product

Behaviour:
- Reset (async) -> state IDLE. Outputs: InReady=1 (decoded from IDLE), OutValid=0, OutAcc=0, OutRangeErr=0, PpMultiplicant=0, PpShift=0, PpNegation=0, PpZero=1. Digit counter=0.
- States: IDLE, RUN, DONE.
- IDLE: InReady=1. InValid=1 latches both operands. Acc is cleared if InClear=1, else kept. RangeErr is cleared, Cnt=0. Next state RUN.
- RUN: InReady=0. The digit for Cnt=i uses bits (b[2i+1], b[2i], b[2i-1]), with b[-1]=0:
  - 000, 111 -> Zero=1, Shift=0, Neg=0
  - 001, 010 -> +1
  - 011 -> +2 (Shift=1)
  - 100 -> -2 (Shift=1, Neg=1)
  - 101, 110 -> -1 (Neg=1)
- Each RUN cycle: Acc <= Acc + (sext(PpResult) << 2i), wrapping modulo 2^ACC_WIDTH with no saturation. Cnt increments. After digit ND-1 -> DONE.
- Partial-product contract: PpResult = Zero ? 0 : ±(Shift ? M<<1 : M), truncated to WIDTH+1 bits.
- Range error: digit -2 with Multiplicant = -2^(WIDTH-1) gives +2^WIDTH, which is unrepresentable. RangeErr is set for that op. The truncated PpResult is still accumulated; no correction.
- DONE: OutValid=1, OutAcc and OutRangeErr held stable. OutReady=1 -> IDLE. OutValid drops the next cycle. Acc is retained for subsequent InClear=0 ops.
- Outside RUN, Pp controls are forced to Zero=1, Shift=0, Neg=0.
- Latency: accept edge -> ND RUN cycles -> OutValid on cycle ND+1 after acceptance. Minimum issue interval is ND+2 cycles.
- InValid while not IDLE is ignored; the producer must hold it until InReady.
- OutAcc updates only in RUN. It is visible but not valid until DONE.
- Reset mid-RUN or mid-DONE: the pending result is lost and Acc=0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RUN/DONE)
  - Booth digit triple constants
  - a function mapping a 3-bit triple to {Shift, Negation, Zero}
- One natural sub-module: booth_digit_encoder (combinational triple -> controls).
- The Multiplier_4X4 unit stays external; the bench wires it to the Pp ports.

Test Plan:
- Reset, then op 3 × 5 with InClear=1 -> digits +1, +1 with PpZero=0, PpShift=0, PpNegation=0 on both RUN cycles; OutAcc=15, OutValid 3 cycles after acceptance, OutRangeErr=0.
- Op -6 (1010) × 7 (0111), InClear=1 -> digit0 -1 (Neg=1), digit1 +2 (Shift=1); OutAcc=-42.
- Back-to-back: 3×5 InClear=1, then 2×-3 InClear=0 -> second result 9. InReady=0 throughout RUN/DONE. An InValid held during busy cycles is accepted only in IDLE.
- Back-pressure: hold OutReady=0 for 5 cycles in DONE -> OutValid/OutAcc stable, InReady=0; release -> IDLE next cycle.
- Range error: -8 × -8, InClear=1 -> digit0 zero, digit1 -2; OutAcc=-64, OutRangeErr=1. Next op 1×1 InClear=1 -> OutRangeErr=0, OutAcc=1.
- Assert Reset during the RUN cycle of 3×5 -> immediately IDLE, InReady=1, OutValid=0, OutAcc=0, PpZero=1. A subsequent 3×5 gives 15.
